// File: rtl/spi_slv_ctrl_if.sv
// Register-bus interface between the SPI slave controller and the core.
//   bus_req   : request, held until ack or timeout
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : word address
//   bus_wdata : write data
//   bus_rdata : read data, valid with bus_ack
//   bus_ack   : single-cycle completion
//   bus_err   : error qualifier, sampled with bus_ack
// master = controller side, slave = register-file side.
interface spi_slv_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/spi_slv_ctrl.sv
// SPI mode-0 slave that turns 89-bit host frames into single-word register
// bus reads/writes. SPI pins are oversampled in the clk domain.
// Frame (sck rises, MSB first):
//   1-8 instr | 9 gap | 10-41 addr |
//   read : 42-49 dummy, 50-81 data out, 82-89 status out
//   write: 42-73 data in, 74-81 dummy, 82-89 status out
// Ports:
//   clk, rst_n         : system clock, async active-low reset
//   sck, ss_n, mosi    : SPI inputs (asynchronous)
//   miso               : SPI data out, changes on sck falls
//   bus                : register-bus master (spi_slv_ctrl_if.master)
//   frame_done         : one-clk pulse after the 89th sck rise
module spi_slv_ctrl #(
    parameter int         TIMEOUT    = 16,
    parameter logic [3:0] STATUS_SIG = 4'hA
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sck,
    input  logic           ss_n,
    input  logic           mosi,
    output logic           miso,
    spi_slv_ctrl_if.master bus,
    output logic           frame_done
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, INSTR, GAP, ADDR, RD_DUMMY, RD_DATA, WR_DATA, WR_DUMMY, STATUS, DONE
    } state_t;

    state_t state, state_nx;

    // ---------------- input synchronizers + edge detect ----------------
    logic [1:0] sck_s, ss_s, mosi_s;
    logic       sck_d, ss_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s  <= 2'b00;
            ss_s   <= 2'b11;
            mosi_s <= 2'b00;
            sck_d  <= 1'b0;
            ss_d   <= 1'b1;
        end else begin
            sck_s  <= {sck_s[0], sck};
            ss_s   <= {ss_s[0], ss_n};
            mosi_s <= {mosi_s[0], mosi};
            sck_d  <= sck_s[1];
            ss_d   <= ss_s[1];
        end
    end

    logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_b;
    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;
    assign ss_fall  = ~ss_s[1] & ss_d;
    assign ss_rise  = ss_s[1] & ~ss_d;
    assign mosi_b   = mosi_s[1];

    // ---------------- frame datapath state ----------------
    logic [6:0]    cnt;        // sck rises seen in this frame
    logic [30:0]   shreg;
    logic [31:0]   shift_in;
    logic [31:0]   addr_q, wdata_q, rd_word;
    logic          rd_q, inv_q, err_f, tmo_f;
    logic          start_pend, we_pend;
    logic          discard;    // outstanding request belongs to an aborted frame
    logic [TW-1:0] tmo_cnt;
    logic          bus_done, rd_pend, abort, out_bit;
    logic [7:0]    status;
    logic [4:0]    bidx;
    logic [2:0]    sidx;

    assign shift_in = {shreg, mosi_b};
    assign status   = {STATUS_SIG, 1'b0, inv_q, tmo_f, err_f};
    assign bus_done = bus.bus_req & (bus.bus_ack | (tmo_cnt == TW'(TIMEOUT - 1)));
    // This frame's read is not yet resolved on the bus.
    assign rd_pend  = start_pend | (bus.bus_req & ~discard);
    // First data-out fall: a read that is still outstanding is given up.
    assign abort    = (state == RD_DATA) && sck_fall && (cnt == 7'd49) && rd_pend;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state != IDLE && ss_rise) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:     if (ss_fall)                     state_nx = INSTR;
                INSTR:    if (sck_rise && cnt == 7'd7)     state_nx = GAP;
                GAP:      if (sck_rise)                    state_nx = ADDR;
                ADDR:     if (sck_rise && cnt == 7'd40)    state_nx = rd_q ? RD_DUMMY : WR_DATA;
                RD_DUMMY: if (sck_rise && cnt == 7'd48)    state_nx = RD_DATA;
                RD_DATA:  if (sck_rise && cnt == 7'd80)    state_nx = STATUS;
                WR_DATA:  if (sck_rise && cnt == 7'd72)    state_nx = WR_DUMMY;
                WR_DUMMY: if (sck_rise && cnt == 7'd80)    state_nx = STATUS;
                STATUS:   if (sck_rise && cnt == 7'd88)    state_nx = DONE;
                DONE:     state_nx = DONE;
                default:  state_nx = IDLE;
            endcase
        end
    end

    // Next miso bit, selected by how many rises have already happened.
    always_comb begin
        out_bit = 1'b0;
        bidx    = 5'(7'd80 - cnt);
        sidx    = 3'(7'd88 - cnt);
        if (state == RD_DATA)     out_bit = rd_word[bidx] & ~rd_pend;
        else if (state == STATUS) out_bit = status[sidx];
    end

    // ---------------- datapath + bus master ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso          <= 1'b0;
            frame_done    <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            cnt           <= '0;
            shreg         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_word       <= '0;
            rd_q          <= 1'b0;
            inv_q         <= 1'b0;
            err_f         <= 1'b0;
            tmo_f         <= 1'b0;
            start_pend    <= 1'b0;
            we_pend       <= 1'b0;
            discard       <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            frame_done <= 1'b0;

            // bus side: one request at a time, orphans drain before new issue
            if (bus.bus_req) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (bus.bus_ack) begin
                    bus.bus_req <= 1'b0;
                    discard     <= 1'b0;
                    if (!discard && !abort) begin
                        if (bus.bus_err) err_f <= 1'b1;
                        if (!bus.bus_we) rd_word <= bus.bus_err ? 32'h0 : bus.bus_rdata;
                    end
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    bus.bus_req <= 1'b0;
                    discard     <= 1'b0;
                    if (!discard) tmo_f <= 1'b1;
                end
            end else if (start_pend) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= we_pend;
                bus.bus_addr  <= addr_q;
                bus.bus_wdata <= wdata_q;
                tmo_cnt       <= '0;
                start_pend    <= 1'b0;
            end

            // frame side (later assignments override the bus side)
            if (state == IDLE) begin
                miso <= 1'b0;
                if (ss_fall) begin
                    cnt        <= '0;
                    rd_q       <= 1'b0;
                    inv_q      <= 1'b0;
                    err_f      <= 1'b0;
                    tmo_f      <= 1'b0;
                    rd_word    <= '0;
                    start_pend <= 1'b0;
                end
            end else if (ss_rise) begin
                miso       <= 1'b0;
                inv_q      <= 1'b0;
                err_f      <= 1'b0;
                tmo_f      <= 1'b0;
                start_pend <= 1'b0;
                // a request still in flight (or issuing this cycle) is orphaned
                if ((bus.bus_req && !bus_done) || (!bus.bus_req && start_pend))
                    discard <= 1'b1;
            end else begin
                if (sck_rise && state != DONE) begin
                    shreg <= shift_in[30:0];
                    cnt   <= cnt + 7'd1;
                    case (cnt)
                        7'd7: begin
                            rd_q  <= (shift_in[7:0] == 8'h01);
                            inv_q <= (shift_in[7:0] >  8'h01);
                        end
                        7'd40: begin
                            addr_q <= shift_in;
                            if (rd_q) begin
                                start_pend <= 1'b1;
                                we_pend    <= 1'b0;
                            end
                        end
                        7'd72: begin
                            if (!rd_q && !inv_q) begin
                                wdata_q    <= shift_in;
                                start_pend <= 1'b1;
                                we_pend    <= 1'b1;
                            end
                        end
                        7'd88: frame_done <= 1'b1;
                        default: ;
                    endcase
                end
                if (sck_fall) miso <= out_bit;
                if (abort) begin
                    if (!(bus.bus_req && discard)) bus.bus_req <= 1'b0;
                    start_pend <= 1'b0;
                    tmo_f      <= 1'b1;
                    rd_word    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slv_ctrl.sv
module tb_spi_slv_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;
    logic frame_done;

    int checks = 0;
    int errors = 0;

    spi_slv_ctrl_if bus_if ();

    spi_slv_ctrl #(.TIMEOUT(16), .STATUS_SIG(4'hA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .bus        (bus_if),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- bus responder ----------------
    int          ack_delay = 3;
    bit          ack_en    = 1'b1;
    bit          err_en    = 1'b0;
    logic [31:0] rd_val    = 32'h0;
    int          req_rises = 0;
    int          req_len   = 0;
    int          last_req_len = 0;
    int          wait_cnt  = 0;
    logic        prev_req  = 1'b0;
    logic        last_we   = 1'b0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    int          fd_cnt    = 0;

    always @(negedge clk) begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_err   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        if (bus_if.bus_req === 1'b1) begin
            if (!prev_req) begin
                req_rises++;
                last_we    = bus_if.bus_we;
                last_addr  = bus_if.bus_addr;
                last_wdata = bus_if.bus_wdata;
                req_len    = 0;
                wait_cnt   = 0;
            end
            req_len++;
            wait_cnt++;
            if (ack_en && wait_cnt == ack_delay) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_err   = err_en;
                bus_if.bus_rdata = rd_val;
            end
        end else if (prev_req) begin
            last_req_len = req_len;
        end
        prev_req = (bus_if.bus_req === 1'b1);
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- SPI master ----------------
    // mv[89-k] holds miso as seen at sck rise k.
    task automatic spi_frame(input logic [7:0] ins, input logic [31:0] adr,
                             input logic [31:0] wd, input bit is_rd,
                             input int n_rises, input bit hold_ss,
                             output logic [88:0] mv);
        logic [88:0] fv;
        fv = is_rd ? {ins, 1'b0, adr, 48'h0} : {ins, 1'b0, adr, wd, 16'h0};
        mv = '0;
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 1; i <= n_rises; i++) begin
            mosi = fv[89-i];
            repeat (8) @(negedge clk);
            mv[89-i] = miso;
            sck = 1'b1;
            repeat (8) @(negedge clk);
            if (!(hold_ss && i == n_rises)) sck = 1'b0;
        end
        if (!hold_ss) begin
            repeat (8) @(negedge clk);
            ss_n = 1'b1;
            mosi = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (4) @(negedge clk);
        checks++;
        if ({miso, bus_if.bus_req, bus_if.bus_we, frame_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {miso, bus_if.bus_req, bus_if.bus_we, frame_done});
        end
        checks++;
        if (bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h expected 0", bus_if.bus_addr, bus_if.bus_wdata);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write;
        logic [88:0] mv;
        int r0, f0;
        r0 = req_rises; f0 = fd_cnt;
        ack_en = 1'b1; ack_delay = 3; err_en = 1'b0;
        spi_frame(8'h00, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 89, 1'b0, mv);
        checks++;
        if (req_rises - r0 !== 1) begin errors++; $display("FAIL wr_req_count: got %0d expected 1", req_rises - r0); end
        checks++;
        if (last_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b expected 1", last_we); end
        checks++;
        if (last_addr !== 32'h10) begin errors++; $display("FAIL wr_addr: got %h expected 00000010", last_addr); end
        checks++;
        if (last_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_wdata: got %h expected cafef00d", last_wdata); end
        checks++;
        if (mv[7:0] !== 8'hA0) begin errors++; $display("FAIL wr_status: got %h expected a0", mv[7:0]); end
        checks++;
        if (mv[88:8] !== 81'h0) begin errors++; $display("FAIL wr_miso_quiet: got %h expected 0", mv[88:8]); end
        checks++;
        if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL wr_frame_done: got %0d expected 1", fd_cnt - f0); end
        checks++;
        if (miso !== 1'b0) begin errors++; $display("FAIL wr_miso_idle: got %b expected 0", miso); end
    endtask

    task automatic test_read;
        logic [88:0] mv;
        int r0, f0;
        r0 = req_rises; f0 = fd_cnt;
        ack_en = 1'b1; ack_delay = 2; err_en = 1'b0; rd_val = 32'h1234_5678;
        spi_frame(8'h01, 32'h0000_0020, 32'h0, 1'b1, 89, 1'b0, mv);
        checks++;
        if (req_rises - r0 !== 1 || last_we !== 1'b0 || last_addr !== 32'h20) begin
            errors++;
            $display("FAIL rd_request: n %0d we %b addr %h expected 1 0 00000020", req_rises - r0, last_we, last_addr);
        end
        checks++;
        if (mv[39:8] !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", mv[39:8]); end
        checks++;
        if (mv[7:0] !== 8'hA0) begin errors++; $display("FAIL rd_status: got %h expected a0", mv[7:0]); end
        checks++;
        if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL rd_frame_done: got %0d expected 1", fd_cnt - f0); end
    endtask

    task automatic test_timeout;
        logic [88:0] mv;
        ack_en = 1'b0; rd_val = 32'hFFFF_FFFF;
        spi_frame(8'h01, 32'h0000_0030, 32'h0, 1'b1, 89, 1'b0, mv);
        ack_en = 1'b1;
        checks++;
        if (last_req_len !== 16) begin errors++; $display("FAIL tmo_req_len: got %0d expected 16", last_req_len); end
        checks++;
        if (mv[39:8] !== 32'h0) begin errors++; $display("FAIL tmo_data: got %h expected 00000000", mv[39:8]); end
        checks++;
        if (mv[7:0] !== 8'hA2) begin errors++; $display("FAIL tmo_status: got %h expected a2", mv[7:0]); end
    endtask

    task automatic test_err;
        logic [88:0] mv;
        ack_en = 1'b1; ack_delay = 3; err_en = 1'b1;
        spi_frame(8'h00, 32'h0000_0044, 32'h0000_0055, 1'b0, 89, 1'b0, mv);
        err_en = 1'b0;
        checks++;
        if (mv[7:0] !== 8'hA1) begin errors++; $display("FAIL err_status: got %h expected a1", mv[7:0]); end
        rd_val = 32'hDEAD_BEEF; ack_delay = 2;
        spi_frame(8'h01, 32'h0000_0048, 32'h0, 1'b1, 89, 1'b0, mv);
        checks++;
        if (mv[7:0] !== 8'hA0) begin errors++; $display("FAIL err_cleared_status: got %h expected a0", mv[7:0]); end
        checks++;
        if (mv[39:8] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_next_data: got %h expected deadbeef", mv[39:8]); end
    endtask

    task automatic test_invalid;
        logic [88:0] mv;
        int r0, f0;
        r0 = req_rises; f0 = fd_cnt;
        spi_frame(8'h05, 32'h0000_0050, 32'hFFFF_FFFF, 1'b0, 89, 1'b0, mv);
        checks++;
        if (req_rises - r0 !== 0) begin errors++; $display("FAIL inv_no_req: got %0d expected 0", req_rises - r0); end
        checks++;
        if (mv[7:0] !== 8'hA4) begin errors++; $display("FAIL inv_status: got %h expected a4", mv[7:0]); end
        checks++;
        if (mv[88:8] !== 81'h0) begin errors++; $display("FAIL inv_miso_quiet: got %h expected 0", mv[88:8]); end
        checks++;
        if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL inv_frame_done: got %0d expected 1", fd_cnt - f0); end
    endtask

    task automatic test_abort;
        logic [88:0] mv;
        int r0, f0;
        r0 = req_rises; f0 = fd_cnt;
        spi_frame(8'h01, 32'h0000_0060, 32'h0, 1'b1, 29, 1'b0, mv);
        checks++;
        if (req_rises - r0 !== 0 || fd_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL abort_quiet: req %0d done %0d expected 0 0", req_rises - r0, fd_cnt - f0);
        end
        ack_en = 1'b1; ack_delay = 2; rd_val = 32'h0A5A_5A5A;
        spi_frame(8'h01, 32'h0000_0064, 32'h0, 1'b1, 89, 1'b0, mv);
        checks++;
        if (last_addr !== 32'h64 || req_rises - r0 !== 1) begin
            errors++;
            $display("FAIL abort_next_req: addr %h n %0d expected 00000064 1", last_addr, req_rises - r0);
        end
        checks++;
        if (mv[39:8] !== 32'h0A5A_5A5A || mv[7:0] !== 8'hA0) begin
            errors++;
            $display("FAIL abort_next_read: data %h status %h expected 0a5a5a5a a0", mv[39:8], mv[7:0]);
        end
        checks++;
        if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL abort_next_done: got %0d expected 1", fd_cnt - f0); end
    endtask

    task automatic test_reset_mid;
        logic [88:0] mv;
        int r0;
        bit seen;
        ack_en = 1'b0;
        spi_frame(8'h01, 32'h0000_0070, 32'h0, 1'b1, 41, 1'b1, mv);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (bus_if.bus_req === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_req_seen: got 0 expected 1"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({miso, bus_if.bus_req, bus_if.bus_we, frame_done} !== 4'b0000 ||
            bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: ctrl %b addr %h wdata %h expected 0",
                     {miso, bus_if.bus_req, bus_if.bus_we, frame_done}, bus_if.bus_addr, bus_if.bus_wdata);
        end
        sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        ack_en = 1'b1; ack_delay = 3; r0 = req_rises;
        spi_frame(8'h00, 32'h0000_0074, 32'h1357_9BDF, 1'b0, 89, 1'b0, mv);
        checks++;
        if (req_rises - r0 !== 1 || last_addr !== 32'h74 || last_wdata !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL rstmid_next_write: n %0d addr %h wdata %h expected 1 00000074 13579bdf",
                     req_rises - r0, last_addr, last_wdata);
        end
        checks++;
        if (mv[7:0] !== 8'hA0) begin errors++; $display("FAIL rstmid_next_status: got %h expected a0", mv[7:0]); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_err;
        test_invalid;
        test_abort;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
